// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, DATA_W data bits LSB first, parity, stop.
// Optional handshake-time parity recheck when PARITY_RECHECK_EN is defined.
module parity_frame_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              even_parity,
  input  logic              odd_parity,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_err
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cyc_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_q;
  logic              tx_q;
  logic              done_q;

  logic hs;
  logic par_sel;
  logic cyc_end;
  logic done_nxt;

  assign par_sel  = (PARITY_ODD != 0) ? odd_parity : even_parity;
  assign hs       = in_valid && (state_q == IDLE);
  assign cyc_end  = (cyc_q == CYC_LAST);

  // Raise frame_done so it lands on the last stop-bit cycle.
  assign done_nxt =
    (state_q == PARITY && cyc_end && BIT_CYCLES == 1) ||
    (state_q == STOP && !cyc_end &&
     int'(cyc_q) == BIT_CYCLES - 2);

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_out     = tx_q;
  assign frame_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_nxt;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            state_q <= START;
            sh_q    <= data_in;
            par_q   <= par_sel;
            tx_q    <= 1'b0;
            cyc_q   <= '0;
          end
        end
        START: begin
          if (cyc_end) begin
            state_q <= DATA;
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        DATA: begin
          if (cyc_end) begin
            cyc_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        PARITY: begin
          if (cyc_end) begin
            state_q <= STOP;
            cyc_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        STOP: begin
          if (cyc_end) begin
            state_q <= IDLE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef PARITY_RECHECK_EN
  logic perr_q;
  logic par_calc;

  assign par_calc = (PARITY_ODD != 0) ? ~^data_in : ^data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= hs && (par_calc != par_sel);
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial framing stage directly downstream of the 4-bit parity generator. It accepts a data word and both parity bits over a valid/ready handshake, then shifts out one asynchronous-style frame: start bit, data LSB first, parity bit, stop bit. A programmable number of clocks is held per bit. This is the block that puts generated parity on the wire.

Parameters:
DATA_W, 4, width of data_in and number of data bits per frame (≥1)
BIT_CYCLES, 4, clocks each frame bit is held on tx_out (≥1)
PARITY_ODD, 0, 0 = transmit even_parity input, 1 = transmit odd_parity input

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_W  word to transmit
even_parity  input  1  even parity bit from generator (= ^data_in)
odd_parity  input  1  odd parity bit from generator (= ~^data_in)
in_valid  input  1  upstream word and parity valid
in_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idles high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit
parity_err  output  1  recheck mismatch pulse (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_out=1, in_ready=1 (after release), busy=0, frame_done=0, parity_err=0; all counters and shift register cleared. Takes effect immediately, without a clock edge.
- in_ready = (state==IDLE). Handshake = in_valid & in_ready at a rising edge.
- On the handshake edge: capture data_in into shift register; capture the selected parity bit (PARITY_ODD). State becomes START and tx_out=0 from that edge.
- States are IDLE → START → DATA → PARITY → STOP → IDLE. Each non-IDLE bit is held for exactly BIT_CYCLES clocks, counted by cyc_cnt (0..BIT_CYCLES-1).
  - DATA sends DATA_W bits LSB first, with bit_cnt 0..DATA_W-1.
  - PARITY sends the captured parity bit.
  - STOP sends 1.
- Frame length = (DATA_W+3)*BIT_CYCLES clocks. State returns to IDLE on the edge ending the stop bit. Minimum spacing between handshakes = frame length + 1 clock.
- busy=1 in every state except IDLE. tx_out is registered and glitch-free; tx_out=1 in IDLE.
- frame_done is high during the final stop-bit cycle only.
- in_valid while busy is ignored: no capture, and the frame in flight is unaffected. Upstream must hold data until in_ready.
- Parity input bits are sampled only at the handshake. Later changes have no effect.
- BIT_CYCLES=1: one clock per bit, and the counter never wraps mid-bit.
- Counter wrap: cyc_cnt resets to 0 at every bit boundary. bit_cnt resets on entry to DATA.
- rst_n asserted mid-frame: the frame is abandoned and tx_out returns to 1 at once. After release, the block is in IDLE and accepts a new word on the first clock edge where in_valid=1.

Optional Feature:
PARITY_RECHECK_EN
- Defined: at the handshake the block recomputes parity from data_in (^data_in, inverted when PARITY_ODD=1) and compares it with the selected input bit. On mismatch, parity_err pulses high for exactly the clock following the handshake. The frame still transmits the supplied (wrong) parity bit.
- Undefined: no recheck logic; parity_err is tied to 0.

Test Plan:
- DATA_W=4, BIT_CYCLES=2, PARITY_ODD=0; handshake data_in=4'b0011, even_parity=0 -> tx_out sequence 0,1,1,0,0,0,1, each bit held 2 clocks (14 clocks total); frame_done pulses in clock 14; busy=1 for 14 clocks.
- PARITY_ODD=1; data_in=4'b0111, odd_parity=0 -> tx_out 0,1,1,1,0,0,1, each bit for 2 clocks.
- in_valid held high with words 4'b1010 then 4'b0101 -> second handshake exactly 15 edges after the first; the second frame starts immediately after one idle-high clock.
- During the first frame, drive in_valid=1 with data_in=4'b1111 while busy -> ignored; the transmitted bits match the originally captured word.
- Assert rst_n=0 during the third data bit -> tx_out=1, busy=0, frame_done=0 without a clock edge. After release, a new handshake starts a clean frame.
- With PARITY_RECHECK_EN and PARITY_ODD=0: data_in=4'b0001, even_parity=0 -> parity_err=1 for one clock after the handshake, parity slot on tx_out = 0. Repeat with even_parity=1 -> parity_err stays 0.
